fifo_burst_reader: RTL and testbench

Read-side engine for the synchronous buffering FIFO in the DMA read datapath. On a start command it pops an exact number of words from the FIFO's `rd_en`/`dout`/`empty` port and hides the FIFO's one-cycle registered read latency. It presents the words as a valid/ready stream with `m_last` on the final word of the burst. It never pops an empty FIFO, and it sustains one word per cycle when the FIFO is non-empty and the sink is ready.

---
 rtl/fifo_burst_reader.sv | 114 +++++++++++
 tb/tb_fifo_burst_reader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Burst read engine for a registered-output sync FIFO: pops exactly len words and
// re-times them onto a valid/ready stream. Optional FIFO_BURST_READER_UNDERRUN_EN adds a stall counter.
module fifo_burst_reader #(
    parameter int BITS_WIDTH = 32,
    parameter int BITS_LEN   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  start,
    input  logic [BITS_LEN-1:0]   len,
    output logic                  busy,
    output logic                  done,
    input  logic [BITS_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [BITS_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
`ifdef FIFO_BURST_READER_UNDERRUN_EN
    ,
    output logic [15:0]           underrun_cycles
`endif
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [BITS_LEN:0] CNT_ONE = 1;

    state_t                state_q, state_d;
    logic                  load;
    logic [BITS_LEN:0]     rd_left, beat_left;
    logic                  inflight;
    logic [BITS_WIDTH-1:0] mem [3];
    logic [1:0]            wr_ptr, rd_ptr, occ;
    logic                  room, beat_xfer, last_xfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Queue slots plus the word still in the FIFO's output register must never exceed 3.
    assign room       = ({1'b0, occ} + {2'b00, inflight}) < 3'd3;
    assign busy       = (state_q == BURST);
    assign fifo_rd_en = busy & ~fifo_empty & (|rd_left) & room;
    assign m_valid    = (occ != 2'd0);
    assign m_data     = mem[rd_ptr];
    assign m_last     = m_valid & (beat_left == CNT_ONE);
    assign beat_xfer  = m_valid & m_ready;
    assign last_xfer  = beat_xfer & (beat_left == CNT_ONE);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = BURST;
                load    = 1'b1;
            end
            BURST: if (last_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rd_left   <= '0;
            beat_left <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            occ       <= 2'd0;
            done      <= 1'b0;
            for (int i = 0; i < 3; i++) mem[i] <= '0;
        end else begin
            state_q  <= state_d;
            done     <= last_xfer;
            inflight <= fifo_rd_en;
            // len of zero encodes the full 2**BITS_LEN burst via the extra MSB
            if (load) begin
                rd_left   <= {(len == '0), len};
                beat_left <= {(len == '0), len};
            end else begin
                if (fifo_rd_en) rd_left   <= rd_left - CNT_ONE;
                if (beat_xfer)  beat_left <= beat_left - CNT_ONE;
            end
            if (inflight) begin
                mem[wr_ptr] <= fifo_dout;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (beat_xfer) rd_ptr <= ptr_inc(rd_ptr);
            unique case ({inflight, beat_xfer})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef FIFO_BURST_READER_UNDERRUN_EN
    logic stall;
    assign stall = busy & (|rd_left) & room & fifo_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            underrun_cycles <= 16'h0000;
        else if (load)
            underrun_cycles <= 16'h0000;
        else if (stall && underrun_cycles != 16'hFFFF)
            underrun_cycles <= underrun_cycles + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a registered-read FIFO model feeds the DUT and a
// negedge monitor logs pops, beats and done pulses for the per-test checks.
module tb_fifo_burst_reader;
    localparam int BITS_WIDTH = 32;
    localparam int BITS_LEN   = 8;

    logic                  i_clk, i_rst_n, start, busy, done;
    logic [BITS_LEN-1:0]   len;
    logic [BITS_WIDTH-1:0] fifo_dout, m_data;
    logic                  fifo_empty, fifo_rd_en, m_valid, m_ready, m_last;
`ifdef FIFO_BURST_READER_UNDERRUN_EN
    logic [15:0]           underrun_cycles;
`endif

    fifo_burst_reader #(.BITS_WIDTH(BITS_WIDTH), .BITS_LEN(BITS_LEN)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .start(start), .len(len), .busy(busy), .done(done),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
`ifdef FIFO_BURST_READER_UNDERRUN_EN
        , .underrun_cycles(underrun_cycles)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // FIFO model: one-cycle registered read, empty when pointers meet
    logic [31:0] fmem [1024];
    int fwp = 0;
    int frp = 0;
    int cyc = 0;
    assign fifo_empty = (fwp == frp);

    initial begin
        fifo_dout = '0;
        forever begin
            @(posedge i_clk);
            cyc <= cyc + 1;
            if (fifo_rd_en) begin
                fifo_dout <= fmem[frp % 1024];
                frp       <= frp + 1;
            end
        end
    end

    task automatic push(input int v);
        fmem[fwp % 1024] = v;
        fwp = fwp + 1;
    endtask

    // Monitor
    int          rd_cyc_q[$];
    logic [31:0] bd_q[$];
    logic        bl_q[$];
    int          bc_q[$];
    int          done_q[$];
    int outst = 0, bpops = 0, ulen = 0, u_model = 0;
    int err_empty = 0, err_occ = 0, err_stab = 0, err_last = 0;
    logic        prev_busy = 1'b0, hold_pend = 1'b0;
    logic [31:0] hold_d = '0;

    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                outst     = 0;
                hold_pend = 1'b0;
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    u_model = 0;
                    bpops   = 0;
                    ulen    = (len == '0) ? 256 : int'(len);
                end
                if (fifo_rd_en && fifo_empty) err_empty++;
                if (fifo_rd_en && outst >= 3) err_occ++;
                if (busy && fifo_empty && bpops < ulen && outst < 3) u_model++;
                if (hold_pend && (!m_valid || m_data !== hold_d)) err_stab++;
                hold_pend = m_valid && !m_ready;
                hold_d    = m_data;
                if (m_last && !m_valid) err_last++;
                if (fifo_rd_en) begin
                    rd_cyc_q.push_back(cyc);
                    bpops++;
                    outst++;
                end
                if (m_valid && m_ready) begin
                    bd_q.push_back(m_data);
                    bl_q.push_back(m_last);
                    bc_q.push_back(cyc);
                    outst--;
                end
                if (done) done_q.push_back(cyc);
                prev_busy = busy;
            end
        end
    end

    // rmode 0: ready always; 1: toggle 1/0 for 12 cycles, low 10 cycles, then high
    task automatic run_burst(input int l, input int rmode, input int fevery, input int fbase,
                             input int fn, input int restart_at, output int cs);
        int   fed = 0;
        int   dbase;
        logic got = 1'b0;
        dbase = done_q.size();
        len   = 8'(l);
        start = 1'b1;
        cs    = cyc + 1;
        @(posedge i_clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rmode == 0) m_ready = 1'b1;
            else if (i < 12) m_ready = (i % 2 == 0);
            else if (i < 22) m_ready = 1'b0;
            else m_ready = 1'b1;
            if (fevery > 0 && fed < fn && i % fevery == 0) begin
                push(fbase + fed);
                fed++;
            end
            if (i == restart_at) begin
                start = 1'b1;
                len   = 8'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge i_clk); #1;
            if (done_q.size() > dbase) begin
                got = 1'b1;
                break;
            end
        end
        start   = 1'b0;
        m_ready = 1'b1;
        check("burst_done_timeout", 32'(got), 1);
    endtask

    task automatic check_beats(input string tag, input int base, input int n, input int first_val);
        check({tag, "_beat_count"}, bd_q.size() - base, n);
        for (int k = 0; k < n && base + k < bd_q.size(); k++) begin
            check({tag, "_data"}, bd_q[base + k], first_val + k);
            check({tag, "_last"}, 32'(bl_q[base + k]), 32'(k == n - 1));
        end
    endtask

    initial begin
        int cs, rb, bb, db;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b1;
        i_rst_n = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd_en", 32'(fifo_rd_en), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_m_data", m_data, 0);
`ifdef FIFO_BURST_READER_UNDERRUN_EN
        check("rst_underrun", 32'(underrun_cycles), 0);
`endif
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Back-to-back throughput
        for (int k = 0; k < 16; k++) push(k);
        rb = rd_cyc_q.size(); bb = bd_q.size(); db = done_q.size();
        run_burst(16, 0, 0, 0, 0, -1, cs);
        repeat (3) @(posedge i_clk); #1;
        check("tp_rd_count", rd_cyc_q.size() - rb, 16);
        if (rd_cyc_q.size() >= rb + 16) begin
            check("tp_rd_first", rd_cyc_q[rb], cs);
            check("tp_rd_last", rd_cyc_q[rb + 15], cs + 15);
        end
        check_beats("tp", bb, 16, 0);
        if (bc_q.size() >= bb + 16) begin
            check("tp_beat_first_cyc", bc_q[bb], cs + 2);
            check("tp_beat_last_cyc", bc_q[bb + 15], cs + 17);
        end
        check("tp_done_count", done_q.size() - db, 1);
        if (done_q.size() > db) check("tp_done_cyc", done_q[db], cs + 18);
        check("tp_busy_after", 32'(busy), 0);

        // Backpressure
        for (int k = 0; k < 8; k++) push(100 + k);
        bb = bd_q.size();
        run_burst(8, 1, 0, 0, 0, -1, cs);
        check_beats("bp", bb, 8, 100);

        // FIFO underrun: one word every 5 cycles
        bb = bd_q.size();
        run_burst(4, 0, 5, 200, 4, -1, cs);
        check_beats("ur", bb, 4, 200);
`ifdef FIFO_BURST_READER_UNDERRUN_EN
        check("ur_count_nonzero", 32'(underrun_cycles != 16'h0), 1);
        check("ur_count", 32'(underrun_cycles), u_model);
`endif

        // Maximum length
        for (int k = 0; k < 256; k++) push(1000 + k);
        bb = bd_q.size();
        run_burst(0, 0, 0, 0, 0, -1, cs);
        check_beats("max", bb, 256, 1000);

        // Start while busy: second start with len=7 must be ignored
        for (int k = 0; k < 4; k++) push(500 + k);
        bb = bd_q.size();
        run_burst(4, 0, 0, 0, 0, 2, cs);
        repeat (5) @(posedge i_clk); #1;
        check_beats("sb", bb, 4, 500);
        check("sb_busy_after", 32'(busy), 0);

        // Reset mid-burst: words 300,301 are popped before reset, 302,303 remain
        for (int k = 0; k < 4; k++) push(300 + k);
        len = 8'd4; m_ready = 1'b0; start = 1'b1;
        @(posedge i_clk); #1;
        start = 1'b0;
        begin
            logic got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (m_valid) begin
                    got = 1'b1;
                    break;
                end
                @(posedge i_clk); #1;
            end
            check("rst_mid_valid_seen", 32'(got), 1);
        end
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_mid_m_valid", 32'(m_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_rd_en", 32'(fifo_rd_en), 0);
        check("rst_mid_m_last", 32'(m_last), 0);
        check("rst_mid_m_data", m_data, 0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        m_ready = 1'b1;
        @(posedge i_clk); #1;
        bb = bd_q.size();
        run_burst(2, 0, 0, 0, 0, -1, cs);
        check_beats("post_rst", bb, 2, 302);

        check("never_pop_empty", err_empty, 0);
        check("never_overfill", err_occ, 0);
        check("stall_stable", err_stab, 0);
        check("last_without_valid", err_last, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
